vectored_interrupt_controller: RTL and testbench
================================================

Name: vectored_interrupt_controller

Overview:
- Multi-source, vectored successor to the single-line interrupt controller.
- Latches falling-edge requests on N_IRQ active-low lines into a pending register and arbitrates them by fixed priority.
- Drains the pipeline before ISR entry and again after URET/SYSTEM fetch, then redirects PC to a per-source vector and back to the saved PC.
- Sits beside the PC module and drives the PC-select mux and the fetch stall.

Parameters:
- N_IRQ, 4, number of interrupt sources (1..16); index 0 is highest priority.
- PC_W, 12, PC and vector width.
- DRAIN_CYCLES, 3, if_clk_en-qualified stall cycles on entry and on exit (>=1).
- VEC_BASE, 12'hF00, address of vector 0.
- VEC_STRIDE, 16, address spacing between vectors.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- PC  in  PC_W  current PC from the PC module.
- if_opcode  in  7  opcode of the fetched instruction; 7'h73 marks the ISR return.
- irq_n  in  N_IRQ  active-low interrupt request lines, synchronous to clk.
- irq_en  in  N_IRQ  per-source enable mask.
- exe_correction  in  2  EXE branch correction; nonzero means PC redirect.
- if_prediction  in  1  IF predicted-taken redirect.
- id_sel_pc  in  1  ID jump redirect.
- if_clk_en  in  1  fetch-stage advance enable.
- sel_ISR  out  1  one-cycle pulse: PC loads isr_vector.
- ret_ISR  out  1  one-cycle pulse: PC loads save_PC.
- ISR_stall  out  1  fetch stall during the drain phases.
- isr_vector  out  PC_W  VEC_BASE + active_id*VEC_STRIDE, truncated to PC_W.
- save_PC  out  PC_W  return address.
- active_id  out  max(1,clog2(N_IRQ))  index of the source being serviced.
- pending  out  N_IRQ  pending request bits.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (nrst low, asynchronous):
  - All outputs 0; state IDLE; drain counter 0.
  - Edge-detect history register all 1s, so a line held low out of reset registers one edge.
- Edge detect: pending[i] sets on a cycle where prev[i]=1 and irq_n[i]=0. prev <= irq_n every cycle.
- Pending clear: pending[i] clears only when source i is accepted. Simultaneous set and clear of the same bit -> set wins.
- Masking: a pending bit with irq_en[i]=0 stays pending and is never accepted while masked.
- Arbitration: the lowest index of (pending & irq_en) wins. Evaluated only in IDLE; no nesting or preemption.
- IDLE:
  - If any request is eligible: active_id <= winner, clear its pending bit, save_PC <= PC, counter <= 0, go to DRAIN_IN.
  - ISR_stall = 0.
- DRAIN_IN:
  - ISR_stall = 1.
  - save_PC <= PC on any cycle where exe_correction!=0, if_prediction or id_sel_pc is high; a later redirect overwrites an earlier one.
  - Counter increments only when if_clk_en is high.
  - When counter==DRAIN_CYCLES-1 and if_clk_en is high: sel_ISR=1 for the next cycle, go to RUN.
- RUN:
  - ISR_stall = 0.
  - When if_opcode==7'h73 and if_clk_en is high: counter <= 0, go to DRAIN_OUT.
  - The 7'h73 opcode is ignored in every other state.
- DRAIN_OUT:
  - ISR_stall = 1.
  - Counter advances as in DRAIN_IN. save_PC is not modified.
  - On the final count, go to RET.
- RET:
  - ret_ISR=1 and ISR_stall=0 for exactly one cycle, then IDLE.
  - Pending requests are evaluated in the following IDLE cycle, giving a minimum of 1 IDLE cycle between ISRs.
- Entry latency: from the eligible request in IDLE to the sel_ISR pulse is DRAIN_CYCLES+1 cycles when if_clk_en is held high. The pulse occurs on the first RUN cycle.
- isr_vector and active_id hold their value from acceptance until the next acceptance.
- Requests arriving in any non-IDLE state only set pending.

Test Plan:
- Single request, default parameters, if_clk_en=1:
  - Stimulus: with PC=12'h040, drive irq_n[2] 1->0.
  - Response: pending=4'b0100 for one cycle, then cleared. save_PC=12'h040, ISR_stall high 3 cycles, sel_ISR pulse, active_id=2, isr_vector=12'hF20.
- Return path:
  - Stimulus: in RUN, present if_opcode=7'h73.
  - Response: ISR_stall high 3 cycles, then a ret_ISR one-cycle pulse, busy drops, save_PC unchanged at 12'h040.
- Priority and masking:
  - Stimulus: irq_n[3] and irq_n[1] fall in the same cycle with irq_en=4'b1101.
  - Response: source 3 is serviced first (1 masked); pending[1] remains set after return. Raising irq_en[1] then triggers service with isr_vector=12'hF10.
- Redirect during drain:
  - Stimulus: in DRAIN_IN, id_sel_pc=1 with PC=12'h0A0, then exe_correction=2'b01 with PC=12'h0B4.
  - Response: save_PC=12'h0B4, and ret_ISR later restores 12'h0B4.
- Fetch stall:
  - Stimulus: if_clk_en low for 2 cycles mid-drain.
  - Response: ISR_stall extends by 2 cycles, and sel_ISR is delayed by 2 cycles.
- Asynchronous reset:
  - Stimulus: nrst pulsed low mid-DRAIN_OUT, between clock edges.
  - Response: outputs clear immediately with no ret_ISR. A new irq_n edge after release is serviced normally.

Source files
------------

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller: edge-latched, fixed-priority requests with
// pipeline drain on ISR entry/exit and PC redirect to a per-source vector.
module vectored_interrupt_controller #(
   parameter int              N_IRQ        = 4,
   parameter int              PC_W         = 12,
   parameter int              DRAIN_CYCLES = 3,
   parameter logic [PC_W-1:0] VEC_BASE     = 12'hF00,
   parameter int              VEC_STRIDE   = 16,
   localparam int             AW           = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [PC_W-1:0]   PC,
   input  logic [6:0]        if_opcode,
   input  logic [N_IRQ-1:0]  irq_n,
   input  logic [N_IRQ-1:0]  irq_en,
   input  logic [1:0]        exe_correction,
   input  logic              if_prediction,
   input  logic              id_sel_pc,
   input  logic              if_clk_en,
   output logic              sel_ISR,
   output logic              ret_ISR,
   output logic              ISR_stall,
   output logic [PC_W-1:0]   isr_vector,
   output logic [PC_W-1:0]   save_PC,
   output logic [AW-1:0]     active_id,
   output logic [N_IRQ-1:0]  pending,
   output logic              busy
);

   // state     | meaning
   // IDLE      | waiting for an eligible request
   // DRAIN_IN  | stalling fetch before ISR entry, tracking redirects
   // RUN       | ISR executing, watching for the return opcode
   // DRAIN_OUT | stalling fetch before returning
   // RET       | one-cycle PC restore from save_PC
   typedef enum logic [2:0] {
      ST_IDLE, ST_DRAIN_IN, ST_RUN, ST_DRAIN_OUT, ST_RET
   } state_t;

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   state_t            state, state_next;
   logic [CW-1:0]     cnt, cnt_next;
   logic [N_IRQ-1:0]  irq_prev, clr, eligible, pending_next;
   logic [AW-1:0]     winner, id_next;
   logic [PC_W-1:0]   save_next, vec_next;
   logic              sel_next, drain_done, redirect;

   assign eligible     = pending & irq_en;
   assign drain_done   = (cnt == CW'(DRAIN_CYCLES - 1));
   assign redirect     = (exe_correction != 2'b00) || if_prediction || id_sel_pc;
   // set beats clear when a new edge lands on the bit being accepted
   assign pending_next = (pending & ~clr) | (irq_prev & ~irq_n);

   always_comb begin
      winner = '0;
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (eligible[i]) winner = AW'(i);
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      save_next  = save_PC;
      id_next    = active_id;
      vec_next   = isr_vector;
      sel_next   = 1'b0;
      clr        = '0;
      case (state)
         ST_IDLE: begin
            if (|eligible) begin
               id_next    = winner;
               vec_next   = VEC_BASE + PC_W'(VEC_STRIDE) * PC_W'(winner);
               clr        = N_IRQ'(1) << winner;
               save_next  = PC;
               cnt_next   = '0;
               state_next = ST_DRAIN_IN;
            end
         end
         ST_DRAIN_IN: begin
            if (redirect) save_next = PC;
            if (if_clk_en) begin
               if (drain_done) begin
                  sel_next   = 1'b1;
                  state_next = ST_RUN;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (if_opcode == 7'h73 && if_clk_en) begin
               cnt_next   = '0;
               state_next = ST_DRAIN_OUT;
            end
         end
         ST_DRAIN_OUT: begin
            if (if_clk_en) begin
               if (drain_done) state_next = ST_RET;
               else            cnt_next   = cnt + 1'b1;
            end
         end
         ST_RET:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         irq_prev   <= '1;
         pending    <= '0;
         save_PC    <= '0;
         active_id  <= '0;
         isr_vector <= '0;
         sel_ISR    <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         irq_prev   <= irq_n;
         pending    <= pending_next;
         save_PC    <= save_next;
         active_id  <= id_next;
         isr_vector <= vec_next;
         sel_ISR    <= sel_next;
      end
   end

   assign ISR_stall = (state == ST_DRAIN_IN) || (state == ST_DRAIN_OUT);
   assign ret_ISR   = (state == ST_RET);
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for vectored_interrupt_controller: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_vectored_interrupt_controller;

   localparam int DRAIN = 3;
   localparam int VB    = 'hF00;
   localparam int VS    = 16;

   logic        clk, nrst;
   logic [11:0] PC;
   logic [6:0]  if_opcode;
   logic [3:0]  irq_n, irq_en;
   logic [1:0]  exe_correction;
   logic        if_prediction, id_sel_pc, if_clk_en;
   logic        sel_ISR, ret_ISR, ISR_stall, busy;
   logic [11:0] isr_vector, save_PC;
   logic [1:0]  active_id;
   logic [3:0]  pending;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   bit [3:0]  m_prev, m_pend;
   bit        m_busy, m_entering, m_ret, m_sel;
   int        m_left, m_id;
   bit [11:0] m_save, m_vec;

   vectored_interrupt_controller dut (
      .clk(clk), .nrst(nrst), .PC(PC), .if_opcode(if_opcode),
      .irq_n(irq_n), .irq_en(irq_en), .exe_correction(exe_correction),
      .if_prediction(if_prediction), .id_sel_pc(id_sel_pc), .if_clk_en(if_clk_en),
      .sel_ISR(sel_ISR), .ret_ISR(ret_ISR), .ISR_stall(ISR_stall),
      .isr_vector(isr_vector), .save_PC(save_PC), .active_id(active_id),
      .pending(pending), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [3:0]  irq_n;
      logic [11:0] pc;
      logic [6:0]  op;
      logic        jmp;
      logic [1:0]  exe;
      logic [3:0]  e_pend;
      logic        e_busy, e_stall, e_sel, e_ret;
      logic [11:0] e_save;
      logic [1:0]  e_id;
      logic [11:0] e_vec;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = '1; m_pend = '0; m_busy = 0; m_entering = 0; m_ret = 0; m_sel = 0;
      m_left = 0; m_id = 0; m_save = '0; m_vec = '0;
   endtask

   task automatic model_update();
      bit [3:0] set_b, clr_b, elig;
      int w;
      bit new_sel, redir;
      if (!nrst) begin
         model_reset();
         return;
      end
      set_b   = m_prev & ~irq_n;
      clr_b   = '0;
      new_sel = 0;
      redir   = (exe_correction != 2'b00) || if_prediction || id_sel_pc;
      if (!m_busy) begin
         elig = m_pend & irq_en;
         if (elig != 0) begin
            w = 0;
            while (!elig[w]) w++;
            clr_b[w]   = 1'b1;
            m_id       = w;
            m_vec      = 12'((VB + w * VS) % 4096);
            m_save     = PC;
            m_busy     = 1;
            m_left     = DRAIN;
            m_entering = 1;
         end
      end else if (m_ret) begin
         m_ret  = 0;
         m_busy = 0;
      end else if (m_left > 0) begin
         if (m_entering && redir) m_save = PC;
         if (if_clk_en) begin
            m_left--;
            if (m_left == 0) begin
               if (m_entering) new_sel = 1;
               else            m_ret   = 1;
            end
         end
      end else if (if_opcode == 7'h73 && if_clk_en) begin
         m_left     = DRAIN;
         m_entering = 0;
      end
      m_sel  = new_sel;
      m_pend = (m_pend & ~clr_b) | set_b;
      m_prev = irq_n;
   endtask

   task automatic compare_model();
      chk("model pending",    pending,    m_pend);
      chk("model busy",       busy,       m_busy);
      chk("model ISR_stall",  ISR_stall,  m_left > 0);
      chk("model sel_ISR",    sel_ISR,    m_sel);
      chk("model ret_ISR",    ret_ISR,    m_ret);
      chk("model save_PC",    save_PC,    m_save);
      chk("model active_id",  active_id,  m_id);
      chk("model isr_vector", isr_vector, m_vec);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_model();
   endtask

   task automatic run_to_idle();
      int k = 0;
      while (m_busy && k < 60) begin
         if_opcode = (m_left == 0 && !m_ret) ? 7'h73 : 7'h00;
         step();
         k++;
      end
      if_opcode = 7'h00;
      chk("run_to_idle busy", busy, 1'b0);
   endtask

   initial begin
      // irq_n pc op jmp exe | pend busy stall sel ret save id vec
      tbl[0]  = '{4'b1011, 12'h040, 7'h00, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0, 12'h000};
      tbl[1]  = '{4'b1011, 12'h040, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[2]  = '{4'b1011, 12'h123, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[3]  = '{4'b1011, 12'h123, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[4]  = '{4'b1011, 12'h123, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[5]  = '{4'b1111, 12'h200, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[6]  = '{4'b1111, 12'h204, 7'h73, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[7]  = '{4'b1111, 12'h208, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[8]  = '{4'b1111, 12'h208, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[9]  = '{4'b1111, 12'h208, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 12'h040, 2'd2, 12'hF20};
      tbl[10] = '{4'b1111, 12'h208, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[11] = '{4'b1110, 12'h050, 7'h00, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 12'h040, 2'd2, 12'hF20};
      tbl[12] = '{4'b1111, 12'h050, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h050, 2'd0, 12'hF00};
      tbl[13] = '{4'b1111, 12'h0A0, 7'h00, 1'b1, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0A0, 2'd0, 12'hF00};
      tbl[14] = '{4'b1111, 12'h0B4, 7'h00, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0B4, 2'd0, 12'hF00};
      tbl[15] = '{4'b1111, 12'h0C8, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0B4, 2'd0, 12'hF00};
      tbl[16] = '{4'b1111, 12'h300, 7'h73, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0B4, 2'd0, 12'hF00};
      tbl[17] = '{4'b1111, 12'h111, 7'h00, 1'b1, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0B4, 2'd0, 12'hF00};
      tbl[18] = '{4'b1111, 12'h111, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0B4, 2'd0, 12'hF00};
      tbl[19] = '{4'b1111, 12'h111, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0B4, 2'd0, 12'hF00};
      tbl[20] = '{4'b1111, 12'h111, 7'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0B4, 2'd0, 12'hF00};

      nrst = 1'b0; PC = 12'h040; if_opcode = 7'h00; irq_n = 4'hF; irq_en = 4'hF;
      exe_correction = 2'b00; if_prediction = 1'b0; id_sel_pc = 1'b0; if_clk_en = 1'b1;
      model_reset();
      #3;
      chk("reset busy",    busy,      1'b0);
      chk("reset stall",   ISR_stall, 1'b0);
      chk("reset pending", pending,   4'h0);
      chk("reset save_PC", save_PC,   12'h000);
      chk("reset vector",  isr_vector, 12'h000);
      @(negedge clk);
      nrst = 1'b1;

      for (int r = 0; r < 21; r++) begin
         irq_n = tbl[r].irq_n; PC = tbl[r].pc; if_opcode = tbl[r].op;
         id_sel_pc = tbl[r].jmp; exe_correction = tbl[r].exe;
         step();
         chk($sformatf("tbl%0d pending", r),    pending,    tbl[r].e_pend);
         chk($sformatf("tbl%0d busy", r),       busy,       tbl[r].e_busy);
         chk($sformatf("tbl%0d ISR_stall", r),  ISR_stall,  tbl[r].e_stall);
         chk($sformatf("tbl%0d sel_ISR", r),    sel_ISR,    tbl[r].e_sel);
         chk($sformatf("tbl%0d ret_ISR", r),    ret_ISR,    tbl[r].e_ret);
         chk($sformatf("tbl%0d save_PC", r),    save_PC,    tbl[r].e_save);
         chk($sformatf("tbl%0d active_id", r),  active_id,  tbl[r].e_id);
         chk($sformatf("tbl%0d isr_vector", r), isr_vector, tbl[r].e_vec);
      end
      id_sel_pc = 1'b0; exe_correction = 2'b00; if_opcode = 7'h00;

      // priority and masking: sources 3 and 1 fall together, 1 masked
      irq_en = 4'b1101; irq_n = 4'b0101;
      step();
      chk("prio pending both", pending, 4'b1010);
      step();
      chk("prio winner id",  active_id,  2'd3);
      chk("prio winner vec", isr_vector, 12'hF30);
      chk("prio pending left", pending, 4'b0010);
      irq_n = 4'b1111;
      run_to_idle();
      chk("masked still pending", pending, 4'b0010);
      step();
      chk("masked not accepted", busy, 1'b0);
      irq_en = 4'b1111;
      step();
      chk("unmask id",  active_id,  2'd1);
      chk("unmask vec", isr_vector, 12'hF10);
      chk("unmask pending clear", pending, 4'b0000);
      run_to_idle();

      // fetch stall during entry drain
      begin
         int k, nst;
         irq_n = 4'b1110;
         step();
         irq_n = 4'b1111;
         step();
         nst = ISR_stall ? 1 : 0;
         k = 0;
         while (k < 20 && !(k > 0 && sel_ISR)) begin
            if_clk_en = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            step();
            k++;
            if (ISR_stall) nst++;
         end
         if_clk_en = 1'b1;
         chk("stall sel latency", k, DRAIN + 2);
         chk("stall length", nst, DRAIN + 2);
         run_to_idle();
      end

      // asynchronous reset in the middle of the exit drain
      begin
         int k = 0;
         irq_n = 4'b1011;
         step();
         irq_n = 4'b1111;
         step();
         while (!(m_busy && m_left == 0 && !m_ret) && k < 20) begin
            step();
            k++;
         end
         chk("reach run", busy && !ISR_stall, 1'b1);
         if_opcode = 7'h73;
         step();
         if_opcode = 7'h00;
         step();
         chk("in drain_out", ISR_stall, 1'b1);
         #2 nrst = 1'b0;
         #1;
         model_reset();
         chk("async busy",    busy,       1'b0);
         chk("async stall",   ISR_stall,  1'b0);
         chk("async ret",     ret_ISR,    1'b0);
         chk("async sel",     sel_ISR,    1'b0);
         chk("async save_PC", save_PC,    12'h000);
         chk("async id",      active_id,  2'd0);
         chk("async vector",  isr_vector, 12'h000);
         @(negedge clk);
         #2 nrst = 1'b1;
         irq_n = 4'b1101;
         step();
         chk("post-reset pending", pending, 4'b0010);
         irq_n = 4'b1111;
         step();
         chk("post-reset id",  active_id,  2'd1);
         chk("post-reset vec", isr_vector, 12'hF10);
         run_to_idle();
      end

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 9) == 0) irq_n[b] = ~irq_n[b];
         if ($urandom_range(0, 49) == 0) irq_en = 4'($urandom);
         PC             = 12'($urandom);
         if_opcode      = ($urandom_range(0, 3) == 0) ? 7'h73 : 7'($urandom);
         if_clk_en      = ($urandom_range(0, 3) != 0);
         exe_correction = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         if_prediction  = ($urandom_range(0, 9) == 0);
         id_sel_pc      = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
